// File: rtl/tlc_pkg.sv
// Shared traffic-light controller definitions: register map, writer states, default widths.
// No logic; imported by tlc and by the register-write initiator.
package tlc_pkg;

    localparam int TLC_ADDR_W = 3;
    localparam int TLC_DATA_W = 8;

    localparam int ADDR_RED    = 0;
    localparam int ADDR_YELLOW = 1;
    localparam int ADDR_GREEN  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } cfg_state_t;

    // Lowest set mask bit gives the fixed red -> yellow -> green order.
    function automatic logic [1:0] first_field(input logic [2:0] mask);
        if (mask[0])
            return 2'd0;
        else if (mask[1])
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/tlc_cfg_timeout.sv
// Clearable saturating wait counter for one handshake phase; expired flags the counting cycle that reaches LIMIT.
// Latency: expired is combinational from the registered count and inc.
// Backpressure: none; clr has priority over inc.
module tlc_cfg_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != 8'(LIMIT)))
            count <= count + 8'd1;
    end

    assign expired = inc && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/tlc_cfg_writer.sv
// Programs tlc red/yellow/green durations over addr/data/valid/ready on a start pulse; abort path under TLC_CFG_TIMEOUT_EN.
// Latency: 4 cycles per write against a one-edge responder, done one cycle after the last GAP exit.
// Backpressure: each write holds valid until ready, then waits for ready low before the next field.
module tlc_cfg_writer
    import tlc_pkg::*;
#(
    parameter int ADDR_WIDTH = TLC_ADDR_W,
    parameter int DATA_WIDTH = TLC_DATA_W,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            wr_mask,
    input  logic [DATA_WIDTH-1:0] red_t,
    input  logic [DATA_WIDTH-1:0] yel_t,
    input  logic [DATA_WIDTH-1:0] grn_t,
    input  logic                  ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("tlc_cfg_writer: TIMEOUT must be 1..255");
    end

    cfg_state_t            state, state_d;
    logic [2:0]            pending, pending_d;
    logic [DATA_WIDTH-1:0] red_q, yel_q, grn_q, red_d, yel_d, grn_d;
    logic [ADDR_WIDTH-1:0] addr_d, faddr;
    logic [DATA_WIDTH-1:0] data_d, fval;
    logic                  valid_d, busy_d, done_d, err_d;
    logic [2:0]            src_mask;
    logic [1:0]            fsel;
    logic                  expired;

    // In IDLE the first field comes straight from the inputs being latched.
    always_comb begin
        src_mask = (state == IDLE) ? wr_mask : pending;
        fsel     = first_field(src_mask);
        faddr    = '0;
        fval     = '0;
        case (fsel)
            2'd0: begin
                faddr = ADDR_WIDTH'(ADDR_RED);
                fval  = (state == IDLE) ? red_t : red_q;
            end
            2'd1: begin
                faddr = ADDR_WIDTH'(ADDR_YELLOW);
                fval  = (state == IDLE) ? yel_t : yel_q;
            end
            default: begin
                faddr = ADDR_WIDTH'(ADDR_GREEN);
                fval  = (state == IDLE) ? grn_t : grn_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state;
        pending_d = pending;
        red_d     = red_q;
        yel_d     = yel_q;
        grn_d     = grn_q;
        addr_d    = addr;
        data_d    = data;
        valid_d   = valid;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = err;
        case (state)
            IDLE: begin
                if (start) begin
                    red_d = red_t;
                    yel_d = yel_t;
                    grn_d = grn_t;
                    err_d = 1'b0;
                    if (wr_mask == 3'b000) begin
                        done_d = 1'b1;
                    end else begin
                        pending_d = wr_mask & ~(3'b001 << fsel);
                        addr_d    = faddr;
                        data_d    = fval;
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                end else if (expired) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (!ready) begin
                    if (pending != 3'b000) begin
                        pending_d = pending & ~(3'b001 << fsel);
                        addr_d    = faddr;
                        data_d    = fval;
                        valid_d   = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            red_q   <= '0;
            yel_q   <= '0;
            grn_q   <= '0;
            addr    <= '0;
            data    <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            pending <= pending_d;
            red_q   <= red_d;
            yel_q   <= yel_d;
            grn_q   <= grn_d;
            addr    <= addr_d;
            data    <= data_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

`ifdef TLC_CFG_TIMEOUT_EN
    // Every state change is an entry into a fresh wait phase (or back to IDLE, where nothing counts).
    tlc_cfg_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_d != state),
        .inc     ((state == WRITE && !ready) || (state == GAP && ready)),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_tlc_cfg_writer.sv
// Directed bench for tlc_cfg_writer against a one-edge tlc register-port responder.
module tb_tlc_cfg_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] wr_mask = 3'b000;
    logic [7:0] red_t = 8'd0;
    logic [7:0] yel_t = 8'd0;
    logic [7:0] grn_t = 8'd0;
    logic       ready = 1'b0;
    logic [2:0] addr;
    logic [7:0] data;
    logic       valid, busy, done, err;

    logic       stall = 1'b0;
    logic [7:0] t_red = 8'd0;
    logic [7:0] t_yel = 8'd0;
    logic [7:0] t_grn = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;

    int         n_wr, done_k, vhigh, stab_bad;
    int         wr_k [3];
    logic [2:0] wr_a [3];
    logic [7:0] wr_d [3];
    logic       err_done, busy_done, busy_k0, err_k0;

    always #5 clk = ~clk;

    tlc_cfg_writer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .wr_mask (wr_mask),
        .red_t   (red_t),
        .yel_t   (yel_t),
        .grn_t   (grn_t),
        .ready   (ready),
        .addr    (addr),
        .data    (data),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // tlc register port: ready follows valid by one edge, register written as ready rises.
    always @(posedge clk) begin
        if (valid && !ready && !stall) begin
            ready <= 1'b1;
            case (addr)
                3'd0: t_red <= data;
                3'd1: t_yel <= data;
                3'd2: t_grn <= data;
                default: ;
            endcase
        end else if (!valid) begin
            ready <= 1'b0;
        end
    end

    // k counts edges after the edge that samples start; observation at the following negedge.
    task automatic run_seq(input logic [2:0] m, input logic [7:0] r, input logic [7:0] y,
                           input logic [7:0] g, input int restart_k, input int stall_k,
                           input int limit);
        logic       prev_v;
        logic [2:0] prev_a;
        logic [7:0] prev_d;
        n_wr = 0; done_k = -1; vhigh = 0; stab_bad = 0;
        err_done = 1'b0; busy_done = 1'b1; busy_k0 = 1'b0; err_k0 = 1'b1;
        @(negedge clk);
        wr_mask = m; red_t = r; yel_t = y; grn_t = g; start = 1'b1;
        stall = (stall_k > 0);
        prev_v = 1'b0; prev_a = addr; prev_d = data;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            start = 1'b0;
            stall = (k < stall_k);
            if (k == restart_k) begin
                start = 1'b1; red_t = 8'd1; yel_t = 8'd1; grn_t = 8'd1; wr_mask = 3'b001;
            end
            if (k == 0) begin
                busy_k0 = busy; err_k0 = err;
            end
            if (valid && !prev_v) begin
                if (n_wr < 3) begin
                    wr_k[n_wr] = k; wr_a[n_wr] = addr; wr_d[n_wr] = data;
                end
                n_wr++;
            end
            if (valid) vhigh++;
            if (valid && prev_v && (addr !== prev_a || data !== prev_d)) stab_bad++;
            prev_v = valid; prev_a = addr; prev_d = data;
            if (done) begin
                done_k = k; err_done = err; busy_done = busy;
                break;
            end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({addr, data, valid, busy, done, err} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%0d data=%0d valid=%b busy=%b done=%b err=%b, required all 0",
                     addr, data, valid, busy, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b busy=%b done=%b, required 000", valid, busy, done);
        end
    endtask

    task automatic test_full_mask;
        run_seq(3'b111, 8'd5, 8'd2, 8'd7, -1, 0, 40);
        n_checks++;
        if (busy_k0 !== 1'b1) begin
            n_fail++; $display("FAIL full_busy_start: busy=%b, required 1", busy_k0);
        end
        n_checks++;
        if (n_wr !== 3) begin
            n_fail++; $display("FAIL full_nwr: got %0d writes, required 3", n_wr);
        end else begin
            n_checks++;
            if ({wr_k[0], wr_k[1], wr_k[2]} !== {32'sd0, 32'sd4, 32'sd8}) begin
                n_fail++;
                $display("FAIL full_write_cycles: %0d/%0d/%0d, required 0/4/8", wr_k[0], wr_k[1], wr_k[2]);
            end
            n_checks++;
            if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1], wr_a[2], wr_d[2]} !==
                {3'd0, 8'd5, 3'd1, 8'd2, 3'd2, 8'd7}) begin
                n_fail++;
                $display("FAIL full_write_vals: (%0d,%0d) (%0d,%0d) (%0d,%0d), required (0,5) (1,2) (2,7)",
                         wr_a[0], wr_d[0], wr_a[1], wr_d[1], wr_a[2], wr_d[2]);
            end
        end
        n_checks++;
        if (done_k !== 12 || busy_done !== 1'b0 || err_done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: done at k=%0d busy=%b err=%b, required k=12 busy=0 err=0",
                     done_k, busy_done, err_done);
        end
        n_checks++;
        if ({t_red, t_yel, t_grn} !== {8'd5, 8'd2, 8'd7}) begin
            n_fail++;
            $display("FAIL full_regs: TRed=%0d TYellow=%0d TGreen=%0d, required 5/2/7", t_red, t_yel, t_grn);
        end
        n_checks++;
        if (stab_bad !== 0) begin
            n_fail++; $display("FAIL full_stable: %0d addr/data changes under valid, required 0", stab_bad);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || addr !== 3'd2 || data !== 8'd7) begin
            n_fail++;
            $display("FAIL full_after: done=%b addr=%0d data=%0d, required done=0 addr=2 data=7", done, addr, data);
        end
    endtask

    task automatic test_partial_mask;
        run_seq(3'b101, 8'd9, 8'd3, 8'd4, -1, 0, 40);
        n_checks++;
        if (n_wr !== 2) begin
            n_fail++; $display("FAIL m101_nwr: got %0d writes, required 2", n_wr);
        end else begin
            n_checks++;
            if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== {3'd0, 8'd9, 3'd2, 8'd4} || wr_k[1] !== 4) begin
                n_fail++;
                $display("FAIL m101_writes: (%0d,%0d) (%0d,%0d) second at k=%0d, required (0,9) (2,4) at k=4",
                         wr_a[0], wr_d[0], wr_a[1], wr_d[1], wr_k[1]);
            end
        end
        n_checks++;
        if (done_k !== 8) begin
            n_fail++; $display("FAIL m101_done: done at k=%0d, required 8", done_k);
        end
        n_checks++;
        if (t_yel !== 8'd2) begin
            n_fail++; $display("FAIL m101_yellow_untouched: TYellow=%0d, required 2", t_yel);
        end
    endtask

    task automatic test_empty_mask;
        run_seq(3'b000, 8'd1, 8'd1, 8'd1, -1, 0, 10);
        n_checks++;
        if (done_k !== 0) begin
            n_fail++; $display("FAIL m000_done: done at k=%0d, required 0", done_k);
        end
        n_checks++;
        if (vhigh !== 0 || n_wr !== 0) begin
            n_fail++; $display("FAIL m000_valid: valid high %0d cycles, required 0", vhigh);
        end
    endtask

    task automatic test_back_to_back;
        run_seq(3'b111, 8'd11, 8'd12, 8'd13, 5, 0, 40);
        n_checks++;
        if (n_wr !== 3 || done_k !== 12) begin
            n_fail++; $display("FAIL restart_flow: %0d writes done k=%0d, required 3 writes k=12", n_wr, done_k);
        end
        n_checks++;
        if ({t_red, t_yel, t_grn} !== {8'd11, 8'd12, 8'd13}) begin
            n_fail++;
            $display("FAIL restart_regs: TRed=%0d TYellow=%0d TGreen=%0d, required 11/12/13", t_red, t_yel, t_grn);
        end
    endtask

`ifdef TLC_CFG_TIMEOUT_EN
    task automatic test_timeout;
        int extra;
        run_seq(3'b111, 8'd31, 8'd32, 8'd33, -1, 1000, 40);
        n_checks++;
        if (vhigh !== 16) begin
            n_fail++; $display("FAIL timeout_valid_len: valid high %0d cycles, required 16", vhigh);
        end
        n_checks++;
        if (done_k !== 16 || err_done !== 1'b1 || busy_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: done k=%0d err=%b busy=%b, required k=16 err=1 busy=0",
                     done_k, err_done, busy_done);
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid) extra++;
        end
        n_checks++;
        if (extra !== 0 || err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_after: valid cycles=%0d err=%b, required 0 and err=1", extra, err);
        end
        run_seq(3'b111, 8'd34, 8'd35, 8'd36, -1, 0, 40);
        n_checks++;
        if (err_k0 !== 1'b0 || err_done !== 1'b0 || done_k !== 12) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b/%b done k=%0d, required err=0 k=12", err_k0, err_done, done_k);
        end
    endtask
`else
    task automatic test_long_stall;
        run_seq(3'b111, 8'd41, 8'd42, 8'd43, -1, 100, 200);
        n_checks++;
        if (vhigh !== 106 || n_wr !== 3) begin
            n_fail++; $display("FAIL stall_valid: valid high %0d cycles in %0d writes, required 106 in 3", vhigh, n_wr);
        end
        n_checks++;
        if (done_k !== 112 || err_done !== 1'b0) begin
            n_fail++; $display("FAIL stall_done: done k=%0d err=%b, required k=112 err=0", done_k, err_done);
        end
        n_checks++;
        if ({t_red, t_yel, t_grn} !== {8'd41, 8'd42, 8'd43}) begin
            n_fail++;
            $display("FAIL stall_regs: TRed=%0d TYellow=%0d TGreen=%0d, required 41/42/43", t_red, t_yel, t_grn);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic       found;
        logic [7:0] g_before;
        g_before = t_grn;
        found = 1'b0;
        @(negedge clk);
        wr_mask = 3'b111; red_t = 8'd21; yel_t = 8'd22; grn_t = 8'd23; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (valid && addr === 3'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rstmid_reach_green: green write not seen, required within 30 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({addr, data, valid, busy, done, err} !== 15'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: addr=%0d data=%0d valid=%b busy=%b done=%b err=%b, required all 0",
                     addr, data, valid, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid, busy, done} !== 3'b000 || t_grn !== g_before) begin
            n_fail++;
            $display("FAIL rstmid_idle: valid=%b busy=%b done=%b TGreen=%0d, required 000 and TGreen=%0d",
                     valid, busy, done, t_grn, g_before);
        end
        run_seq(3'b111, 8'd51, 8'd52, 8'd53, -1, 0, 40);
        n_checks++;
        if ({t_red, t_yel, t_grn} !== {8'd51, 8'd52, 8'd53} || done_k !== 12) begin
            n_fail++;
            $display("FAIL rstmid_fresh: TRed=%0d TYellow=%0d TGreen=%0d done k=%0d, required 51/52/53 k=12",
                     t_red, t_yel, t_grn, done_k);
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_partial_mask();
        test_empty_mask();
        test_back_to_back();
`ifdef TLC_CFG_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
